// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: groups the request/ack handshakes of both requesters and
// the data-memory bus. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requests and models the memory.
interface dmem_arbiter_if;
  logic        a_req;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_we;
  logic [2:0]  a_funct3;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        a_err;

  logic        b_req;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_we;
  logic [2:0]  b_funct3;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  a_req, a_addr, a_wdata, a_we, a_funct3,
    input  b_req, b_addr, b_wdata, b_we, b_funct3,
    input  mem_rdata,
    output a_ack, a_rdata, a_err,
    output b_ack, b_rdata, b_err,
    output mem_addr, mem_wdata, mem_funct3, mem_read, mem_write
  );

  modport master (
    output a_req, a_addr, a_wdata, a_we, a_funct3,
    output b_req, b_addr, b_wdata, b_we, b_funct3,
    output mem_rdata,
    input  a_ack, a_rdata, a_err,
    input  b_ack, b_rdata, b_err,
    input  mem_addr, mem_wdata, mem_funct3, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core LSU
// (port A) and a debug/DMA loader (port B). One access at a time runs through
// IDLE -> SERVE -> DONE; ties are broken round-robin.
// Optional feature: define DMEM_ARB_CORE_PRIO_EN to make port A win every tie
// (fixed priority); `last` is then still tracked but not consulted.
module dmem_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          busy
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        gnt;
  logic        gnt_next;
  logic        last;
  logic        winner;
  logic        err_pending;

  logic        a_ack_q;
  logic        b_ack_q;
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;

  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_funct3;
  logic        sel_we;
  logic        in_range;
  logic [31:0] load_data;

  logic [31:0] mem_addr_c;
  logic [31:0] mem_wdata_c;
  logic [2:0]  mem_funct3_c;
  logic        mem_read_c;
  logic        mem_write_c;

  // Route the granted port's request fields and qualify its address range
  always_comb begin
    sel_addr   = gnt ? bus.b_addr   : bus.a_addr;
    sel_wdata  = gnt ? bus.b_wdata  : bus.a_wdata;
    sel_funct3 = gnt ? bus.b_funct3 : bus.a_funct3;
    sel_we     = gnt ? bus.b_we     : bus.a_we;
    in_range   = (sel_addr < DEPTH_W);
    load_data  = in_range ? bus.mem_rdata : 32'h0;
  end

  // Choose the port that would be granted if the sequencer were idle now
  always_comb begin
    winner = 1'b0;
    if (bus.a_req && bus.b_req) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last;
`endif
    end else if (bus.b_req) begin
      winner = 1'b1;
    end
  end

  // Sequencer state and grant register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
    end
  end

  // Next-state logic and memory-side outputs; the bus is quiet outside SERVE
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    mem_addr_c   = 32'h0;
    mem_wdata_c  = 32'h0;
    mem_funct3_c = 3'b000;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          gnt_next   = winner;
          state_next = SERVE;
        end
      end
      SERVE: begin
        mem_addr_c   = sel_addr;
        mem_wdata_c  = sel_wdata;
        mem_funct3_c = sel_funct3;
        mem_read_c   = ~sel_we & in_range;
        mem_write_c  = sel_we & in_range;
        state_next   = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture load data and raise the granted ack at the end of SERVE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= 32'h0;
      b_rdata_q   <= 32'h0;
      err_pending <= 1'b0;
      last        <= 1'b1;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      if (state == SERVE) begin
        err_pending <= ~in_range;
        if (gnt) begin
          b_ack_q   <= 1'b1;
          b_rdata_q <= load_data;
        end else begin
          a_ack_q   <= 1'b1;
          a_rdata_q <= load_data;
        end
      end
      if (state == DONE) begin
        last <= gnt;
      end
    end
  end

  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.a_err      = a_ack_q & err_pending;
  assign bus.b_err      = b_ack_q & err_pending;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_funct3 = mem_funct3_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives both requester ports from per-port request queues,
// models the data memory, and checks every cycle against a transaction-level
// reference (a free-at-edge schedule plus a shadow copy of memory).
module tb_dmem_arbiter;

  localparam int          DEPTH   = 64;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
`ifdef DMEM_ARB_CORE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } op_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic mem_init;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 1) ? 32'hAAAAAAAA : 32'(i) * 32'h01010101;
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] w, logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(logic [31:0] old, logic [31:0] d, logic [2:0] f3);
    case (f3)
      3'b000:  return {old[31:8], d[7:0]};
      3'b001:  return {old[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Data memory: combinational read, write at the clock edge
  logic [31:0] ram [DEPTH];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (bus.mem_write && bus.mem_addr < DEPTH_W) begin
      ram[bus.mem_addr[5:0]] <= store_val(ram[bus.mem_addr[5:0]], bus.mem_wdata, bus.mem_funct3);
    end
  end

  always_comb begin
    bus.mem_rdata = (bus.mem_addr < DEPTH_W) ? load_val(ram[bus.mem_addr[5:0]], bus.mem_funct3) : 32'h0;
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  op_t         qa[$];
  op_t         qb[$];
  int          cyc;
  int          present_a;
  int          present_b;
  int          free_edge;
  logic        last_b;
  logic        inflight;
  int          serve_edge;
  op_t         cur;
  logic [31:0] cur_rdata;
  logic        cur_err;
  int          gap_max;
  logic        done_port_q[$];
  int          done_edge_q[$];
  logic [31:0] last_rdata;
  logic        last_err;

  int n_cmp;
  int n_fail;

  vec_t vecs[12];

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus();
    bus.a_req = (qa.size() > 0) && (cyc >= present_a);
    if (bus.a_req) begin
      bus.a_addr = qa[0].addr; bus.a_wdata = qa[0].wdata; bus.a_we = qa[0].we; bus.a_funct3 = qa[0].f3;
    end else begin
      bus.a_addr = 32'h0; bus.a_wdata = 32'h0; bus.a_we = 1'b0; bus.a_funct3 = 3'b000;
    end
    bus.b_req = (qb.size() > 0) && (cyc >= present_b);
    if (bus.b_req) begin
      bus.b_addr = qb[0].addr; bus.b_wdata = qb[0].wdata; bus.b_we = qb[0].we; bus.b_funct3 = qb[0].f3;
    end else begin
      bus.b_addr = 32'h0; bus.b_wdata = 32'h0; bus.b_we = 1'b0; bus.b_funct3 = 3'b000;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    checkOutput({tag, "_busy"},      busy,           32'h0);
    checkOutput({tag, "_a_ack"},     bus.a_ack,      32'h0);
    checkOutput({tag, "_b_ack"},     bus.b_ack,      32'h0);
    checkOutput({tag, "_a_err"},     bus.a_err,      32'h0);
    checkOutput({tag, "_b_err"},     bus.b_err,      32'h0);
    checkOutput({tag, "_a_rdata"},   bus.a_rdata,    32'h0);
    checkOutput({tag, "_b_rdata"},   bus.b_rdata,    32'h0);
    checkOutput({tag, "_mem_read"},  bus.mem_read,   32'h0);
    checkOutput({tag, "_mem_write"}, bus.mem_write,  32'h0);
    checkOutput({tag, "_mem_addr"},  bus.mem_addr,   32'h0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata,  32'h0);
    checkOutput({tag, "_mem_f3"},    bus.mem_funct3, 32'h0);
  endtask

  // One clock of the engine: drive, predict, clock, compare, retire
  task automatic step();
    logic        win;
    logic        rng;
    logic        e_busy, e_read, e_write, e_ack_a, e_ack_b;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_f3;
    int          gap;
    applyStimulus();
    if (!inflight && cyc >= free_edge && (bus.a_req || bus.b_req)) begin
      if (bus.a_req && bus.b_req) win = PRIO ? 1'b0 : ~last_b;
      else                        win = bus.b_req;
      last_b     = win;
      cur        = win ? qb[0] : qa[0];
      cur.port   = win;
      inflight   = 1'b1;
      serve_edge = cyc;
      rng        = (cur.addr < DEPTH_W);
      cur_err    = ~rng;
      cur_rdata  = (rng && !cur.we) ? load_val(ref_mem[cur.addr[5:0]], cur.f3) : 32'h0;
      if (rng && cur.we) ref_mem[cur.addr[5:0]] = store_val(ref_mem[cur.addr[5:0]], cur.wdata, cur.f3);
    end
    e_busy = 1'b0; e_read = 1'b0; e_write = 1'b0; e_ack_a = 1'b0; e_ack_b = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; e_f3 = 3'b000;
    if (inflight && cyc == serve_edge) begin
      rng     = (cur.addr < DEPTH_W);
      e_busy  = 1'b1;
      e_read  = ~cur.we & rng;
      e_write = cur.we & rng;
      e_addr  = cur.addr;
      e_wdata = cur.wdata;
      e_f3    = cur.f3;
    end
    if (inflight && cyc == serve_edge + 1) begin
      e_busy  = 1'b1;
      e_ack_a = ~cur.port;
      e_ack_b = cur.port;
    end
    @(posedge clk);
    #1;
    checkOutput("busy",      busy,           e_busy);
    checkOutput("mem_read",  bus.mem_read,   e_read);
    checkOutput("mem_write", bus.mem_write,  e_write);
    checkOutput("mem_addr",  bus.mem_addr,   e_addr);
    checkOutput("mem_wdata", bus.mem_wdata,  e_wdata);
    checkOutput("mem_f3",    bus.mem_funct3, e_f3);
    checkOutput("a_ack",     bus.a_ack,      e_ack_a);
    checkOutput("b_ack",     bus.b_ack,      e_ack_b);
    checkOutput("a_err",     bus.a_err,      e_ack_a & cur_err);
    checkOutput("b_err",     bus.b_err,      e_ack_b & cur_err);
    if (e_ack_a && !cur.we) checkOutput("a_rdata", bus.a_rdata, cur_rdata);
    if (e_ack_b && !cur.we) checkOutput("b_rdata", bus.b_rdata, cur_rdata);
    if (inflight && cyc == serve_edge + 1) begin
      gap        = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      last_rdata = cur.port ? bus.b_rdata : bus.a_rdata;
      last_err   = cur.port ? bus.b_err : bus.a_err;
      done_port_q.push_back(cur.port);
      done_edge_q.push_back(cyc);
      if (cur.port) begin
        void'(qb.pop_front());
        present_b = cyc + 1 + gap;
      end else begin
        void'(qa.pop_front());
        present_a = cyc + 1 + gap;
      end
      inflight  = 1'b0;
      free_edge = cyc + 2;
    end
    cyc++;
  endtask

  task automatic run_until_idle(int bound);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || inflight) && n < bound) begin
      step();
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0 || inflight) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d/%0d ops still queued after %0d cycles, expected 0", qa.size(), qb.size(), bound);
    end
  endtask

  task automatic push_op(logic port, logic we, logic [31:0] addr, logic [31:0] wdata, logic [2:0] f3);
    op_t o;
    o.port = port; o.we = we; o.addr = addr; o.wdata = wdata; o.f3 = f3;
    if (port) qb.push_back(o);
    else      qa.push_back(o);
  endtask

  task automatic model_after_reset();
    qa.delete();
    qb.delete();
    inflight  = 1'b0;
    last_b    = 1'b1;
    free_edge = cyc;
    present_a = cyc;
    present_b = cyc;
    cur_err   = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    int          issued;
    logic [31:0] ad;
    logic [2:0]  f3;
    logic        we;
    logic        exp_port;
    logic [2:0]  load_f3s [5];
    load_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    n_cmp = 0; n_fail = 0; cyc = 0; gap_max = 0;
    rst = 1'b1; mem_init = 1'b1;
    bus.a_req = 1'b0; bus.a_addr = 32'h0; bus.a_wdata = 32'h0; bus.a_we = 1'b0; bus.a_funct3 = 3'b000;
    bus.b_req = 1'b0; bus.b_addr = 32'h0; bus.b_wdata = 32'h0; bus.b_we = 1'b0; bus.b_funct3 = 3'b000;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0; mem_init = 1'b0;
    model_after_reset();

    // Directed vectors, applied one transaction at a time
    vecs[0]  = '{1'b0, 1'b0, 32'd1,         32'h0,        3'b010, 32'hAAAAAAAA, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 32'd5,         32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'd5,         32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'd5,         32'h0,        3'b000, 32'hFFFFFFEF, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'd5,         32'h0,        3'b100, 32'h000000EF, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'd64,        32'h12345678, 3'b010, 32'h0,        1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'd64,        32'h0,        3'b010, 32'h0,        1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'd5,         32'h0,        3'b001, 32'hFFFFBEEF, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'd5,         32'h00000011, 3'b000, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'd5,         32'h0,        3'b101, 32'h0000BE11, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFFFFFF,  32'h0,        3'b010, 32'h0,        1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'd63,        32'h0,        3'b010, 32'h3F3F3F3F, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      push_op(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3);
      run_until_idle(20);
      checkOutput($sformatf("vec%0d_err", i), last_err, vecs[i].exp_err);
      if (vecs[i].chk_rdata) checkOutput($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
    end

    // Reset in the SERVE cycle of a B load suppresses its ack
    push_op(1'b1, 1'b0, 32'd7, 32'h0, 3'b010);
    n = 0;
    do begin
      step();
      n++;
    end while (!(inflight && serve_edge == cyc - 1) && n < 10);
    checkOutput("rst_mid_reached_serve", inflight && serve_edge == cyc - 1, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    model_after_reset();
    push_op(1'b0, 1'b0, 32'd1, 32'h0, 3'b010);
    run_until_idle(20);
    checkOutput("post_rst_a_rdata", last_rdata, 32'hAAAAAAAA);

    // Held request after ack is a second access, acked 3 cycles later
    done_edge_q.delete();
    done_port_q.delete();
    push_op(1'b0, 1'b0, 32'd2, 32'h0, 3'b010);
    push_op(1'b0, 1'b0, 32'd3, 32'h0, 3'b010);
    run_until_idle(20);
    checkOutput("hold_count", done_edge_q.size(), 32'd2);
    if (done_edge_q.size() == 2) checkOutput("hold_spacing", done_edge_q[1] - done_edge_q[0], 32'd3);

    // Continuous contention: one B access first so A wins the opening tie
    push_op(1'b1, 1'b0, 32'd4, 32'h0, 3'b010);
    run_until_idle(20);
    done_edge_q.delete();
    done_port_q.delete();
    for (int k = 0; k < 4; k++) begin
      push_op(1'b0, 1'b0, 32'(10 + k), 32'h0, 3'b010);
      push_op(1'b1, 1'b0, 32'(20 + k), 32'h0, 3'b010);
    end
    present_a = cyc;
    present_b = cyc;
    run_until_idle(60);
    checkOutput("contention_count", done_port_q.size(), 32'd8);
    for (int k = 0; k < done_port_q.size() && k < 8; k++) begin
      exp_port = PRIO ? (k >= 4) : (k % 2 == 1);
      checkOutput($sformatf("contention_order%0d", k), done_port_q[k], exp_port);
      if (k > 0) checkOutput($sformatf("contention_spacing%0d", k), done_edge_q[k] - done_edge_q[k-1], 32'd3);
    end

    // Randomized traffic against the reference model
    gap_max = 3;
    issued  = 0;
    n       = 0;
    while ((issued < 200 || qa.size() != 0 || qb.size() != 0 || inflight) && n < 4000) begin
      if (issued < 200 && $urandom_range(2, 0) == 0) begin
        case ($urandom_range(9, 0))
          7:       ad = 32'd64 + 32'($urandom_range(16, 0));
          8:       ad = $urandom;
          9:       ad = 32'd63;
          default: ad = 32'($urandom_range(63, 0));
        endcase
        we = 1'($urandom_range(1, 0));
        f3 = we ? 3'($urandom_range(2, 0)) : load_f3s[$urandom_range(4, 0)];
        push_op(1'($urandom_range(1, 0)), we, ad, $urandom, f3);
        issued++;
      end
      step();
      n++;
    end
    checkOutput("random_drained", 32'(qa.size() + qb.size()) + 32'(inflight), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory between two requesters: the core load/store unit (port A) and a debug/DMA loader (port B).
- Runs a three-state sequencer that grants, performs and acknowledges one access at a time.
- Arbitration is round-robin; requesters see a req/ack handshake.
- Sits between the MEM stage / debug unit and the data memory. It drives the memory's `address`, `writeData`, `memRead`, `memWrite` and `funct3` inputs and samples its combinational `readData`.

## Interface
- `DEPTH`, 64, number of 32-bit words in the data memory; word addresses ≥ `DEPTH` are rejected.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_req`, `b_req`  in  1  access request; held high until the matching ack.
- `a_addr`, `b_addr`  in  32  word address; held stable while req is high.
- `a_wdata`, `b_wdata`  in  32  store data.
- `a_we`, `b_we`  in  1  1 = store, 0 = load.
- `a_funct3`, `b_funct3`  in  3  width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW), passed through unchanged.
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  32  registered load data; valid while the matching ack is high.
- `a_err`, `b_err`  out  1  high together with ack when the address was out of range.
- `mem_addr`  out  32  to memory `address`.
- `mem_wdata`  out  32  to memory `writeData`.
- `mem_funct3`  out  3  to memory `funct3`.
- `mem_read`, `mem_write`  out  1  to memory `memRead` / `memWrite`.
- `mem_rdata`  in  32  from memory `readData`.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, SERVE, DONE. Reset value is IDLE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: latch the winner into `gnt` (0 = A, 1 = B), then go to SERVE.
- Winner selection when only one port requests: that port wins.
- Winner selection when both ports request: the port not equal to `last` wins. `last` resets to B, so A wins the first tie.
- SERVE, one cycle:
  - `mem_addr`, `mem_wdata` and `mem_funct3` come from the granted port.
  - `mem_write` = granted `we` AND address in range.
  - `mem_read` = NOT `we` AND address in range.
  - `mem_rdata` is captured into the granted port's rdata register. Store data is written by the memory at the end of SERVE.
  - Set err_pending = NOT (addr < `DEPTH`), comparing the full 32-bit address as unsigned. Out-of-range loads return rdata = 0.
  - Next state is DONE.
- DONE, one cycle: pulse the granted ack; the granted err equals err_pending. Set `last` ← `gnt`, then go to IDLE.
- Outside SERVE: `mem_read` = `mem_write` = 0 and `mem_addr`/`mem_wdata`/`mem_funct3` = 0, so the memory never sees a stray write.
- The non-granted port's ack, err and rdata registers stay unchanged.
- A requester drops req in the cycle its ack is high. A req still high in the IDLE cycle that follows is a new request.
- Reset mid-operation (SERVE or DONE): return to IDLE and suppress the pending ack. A memory write already issued in SERVE is not undone.
- Reset values: all acks/errs 0, both rdata 0, `busy` 0, `gnt` 0, `last` = B, every `mem_*` output 0.

## Timing
- Request first sampled high at edge 0 (IDLE) → SERVE during cycle 1 → ack high during cycle 2.
- Load latency is 2 cycles from req sampled to ack.
- Peak throughput is one access per 3 cycles. Under continuous contention A and B alternate.
- A store is visible in memory from the edge that ends SERVE. A load issued next by either port returns the new value.
- A req that rises while `busy` is high waits for IDLE. No request is dropped or reordered within a port.

## Configuration
- `DMEM_ARB_CORE_PRIO_EN` defined: fixed priority, A (core) always wins a tie. `last` is still maintained but ignored. B can starve only under back-to-back core traffic.
- `DMEM_ARB_CORE_PRIO_EN` undefined: round-robin exactly as described under Operation.

## Test plan
- After reset, A load LW of addr 1 → `mem_read` high for exactly one cycle. `a_ack` 2 cycles after req with `a_rdata` = 0xAAAAAAAA. `b_ack` stays 0.
- B store SW of 0xDEADBEEF to addr 5, then A load LW of addr 5 → `a_rdata` = 0xDEADBEEF. Then A load LB of addr 5 → 0xFFFFFFEF; LBU of addr 5 → 0x000000EF.
- A and B both request at the same edge, held continuously for 4 transactions each → grants alternate A, B, A, B… with acks 3 cycles apart. With `DMEM_ARB_CORE_PRIO_EN` defined, all A transactions complete first.
- A store to addr 64 → `mem_write` never asserts; `a_ack` and `a_err` are high together. A following load of addr 64 → `a_rdata` = 0, `a_err` = 1.
- `rst` asserted in the SERVE cycle of a B load → no `b_ack`. State is IDLE and all outputs are at reset values on the next cycle. A new A request then completes normally.
- Req held high one cycle after ack → treated as a second access; a second ack follows 3 cycles later.
